// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer.
// Owns the architectural PC and issues req/ack fetches to instruction memory.
// Handles branch redirects, including one that arrives while a request is
// still outstanding. Also handles ID-stage stalls through a one-entry
// overflow buffer. Presents one registered slot (valid/instr/pc) to decode.
// Optional build macro FETCH_PERF_EN adds saturating counters for stall cycles
// and branch redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        stall_i,
    input  logic        branch_sig_i,
    input  logic [31:0] pc_branch_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;  // request outstanding at pc_q
    localparam logic [1:0] ST_FLUSH = 2'd2;  // stale request draining, data discarded
    localparam logic [1:0] ST_HOLD  = 2'd3;  // slot blocked, fetched word parked in buf

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] flush_addr_q, flush_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] slot_pc_q, slot_pc_d;

    logic ack_take;
    logic slot_free;

    // Request/address outputs depend only on the state, never on inputs
    always_comb begin
        imem_req_o  = (state_q == ST_REQ) || (state_q == ST_FLUSH);
        imem_addr_o = 32'd0;
        if (state_q == ST_REQ) begin
            imem_addr_o = pc_q;
        end else if (state_q == ST_FLUSH) begin
            imem_addr_o = flush_addr_q;
        end
    end

    assign ack_take   = imem_req_o && imem_ack_i;
    assign slot_free  = !valid_q || !stall_i;
    assign if_valid_o = valid_q;
    assign if_instr_o = instr_q;
    assign if_pc_o    = slot_pc_q;

    // Next-state logic: fetch sequencing, slot refill and branch override
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_addr_d = flush_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        slot_pc_d    = slot_pc_q;

        // Decode takes the slot on every edge it is not stalled
        if (!stall_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_take) begin
                    if (!branch_sig_i) begin
                        pc_d = pc_q + PC_STEP;
                        if (slot_free) begin
                            valid_d   = 1'b1;
                            instr_d   = imem_rdata_i;
                            slot_pc_d = pc_q;
                        end else begin
                            buf_instr_d = imem_rdata_i;
                            buf_pc_d    = pc_q;
                            state_d     = ST_HOLD;
                        end
                    end
                end else if (branch_sig_i) begin
                    // Outstanding request cannot be withdrawn: keep its address
                    flush_addr_d = pc_q;
                    state_d      = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (ack_take) begin
                    state_d = ST_REQ;
                end
            end
            default: begin  // ST_HOLD
                if (!stall_i) begin
                    valid_d   = 1'b1;
                    instr_d   = buf_instr_q;
                    slot_pc_d = buf_pc_q;
                    state_d   = ST_REQ;
                end
            end
        endcase

        // A redirect beats stall and slot load; the last branch seen wins
        if (branch_sig_i) begin
            pc_d    = pc_branch_i;
            valid_d = 1'b0;
            if (state_q == ST_HOLD || state_q == ST_IDLE) begin
                state_d = ST_REQ;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            flush_addr_q <= 32'd0;
            buf_instr_q  <= 32'd0;
            buf_pc_q     <= 32'd0;
            valid_q      <= 1'b0;
            instr_q      <= 32'd0;
            slot_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_addr_q <= flush_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            slot_pc_q    <= slot_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating counters: stalled-with-valid-slot cycles and branch pulses
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (valid_q && stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (branch_sig_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the IF stage. Owns the architectural PC register and issues req/ack transactions to instruction memory. Handles branch redirects and ID-stage stalls, and presents one registered instruction slot (valid/instr/pc) to the IF/ID boundary. Sits between the hazard/branch logic, IMEM and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, PC increment after each accepted fetch

Ports:
CLK  in  1  clock, all state updates on rising edge
RSTN  in  1  asynchronous active-low reset
STALL  in  1  ID cannot accept the slot this cycle
BRANCH_SIG  in  1  redirect request, 1-cycle pulse
PC_BRANCH  in  32  redirect target, valid with BRANCH_SIG
IMEM_REQ  out  1  fetch request, held until IMEM_ACK
IMEM_ADDR  out  32  fetch address, stable while IMEM_REQ=1
IMEM_ACK  in  1  transaction complete, IMEM_RDATA valid this cycle
IMEM_RDATA  in  32  fetched instruction
IF_VALID  out  1  slot holds a valid instruction
IF_INSTR  out  32  slot instruction
IF_PC  out  32  address of slot instruction

Behaviour:
- Reset (RSTN=0, async): state=IDLE, pc=RESET_PC, buf cleared, IF_VALID=0, IF_INSTR=0, IF_PC=0. IMEM_REQ=0.
- IMEM_REQ=1 iff state in {REQ, FLUSH}. IMEM_ADDR=pc in REQ, old address in FLUSH; 0 in IDLE.
- A transaction ends in the cycle IMEM_ACK=1 while IMEM_REQ=1. ACK with REQ=0 is ignored.
- Slot consumption: slot is consumed on every edge with STALL=0. IF_VALID drops to 0 unless the slot is refilled that edge.
- IDLE: go to REQ on the next edge. First IMEM_REQ is seen in cycle 1 after reset release.
- REQ, ACK=1, BRANCH_SIG=0:
  - If slot is free (IF_VALID=0 or STALL=0): load slot (IF_INSTR=RDATA, IF_PC=pc, IF_VALID=1) and set pc=pc+PC_STEP (mod 2^32). Stay in REQ; back-to-back fetch, 1 instr/cycle at zero-wait IMEM.
  - Else: capture RDATA/pc into buf, set pc+=PC_STEP, go to HOLD.
- REQ, ACK=0, BRANCH_SIG=1: an outstanding request cannot be withdrawn. Set pc=PC_BRANCH and go to FLUSH; the old address is kept on IMEM_ADDR.
- REQ, ACK=1, BRANCH_SIG=1: discard RDATA, set pc=PC_BRANCH, stay in REQ. The new address is issued next cycle.
- FLUSH: hold REQ and the old address until ACK. Discard data and go to REQ. A further BRANCH_SIG in FLUSH overwrites pc (last branch wins).
- HOLD: IMEM_REQ=0.
  - When STALL=0: the slot is consumed, buf moves into the slot, go to REQ.
  - BRANCH_SIG in HOLD: drop buf, set pc=PC_BRANCH, go to REQ.
- Any BRANCH_SIG: IF_VALID=0 on the next edge, regardless of STALL. Branch has priority over stall and over slot load.
- PC wraps 32'hFFFF_FFFC+4 -> 0 with no flag.
- Reset mid-transaction returns to IDLE immediately. A late ACK after reset is ignored (REQ=0).

Optional Feature:
FETCH_PERF_EN: adds outputs PERF_STALL_CNT[31:0] (cycles with IF_VALID=1 and STALL=1) and PERF_FLUSH_CNT[31:0] (BRANCH_SIG pulses). Both counters are saturating, reset to 0, and sit on the CLK/RSTN domain. Without the macro these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then zero-wait IMEM (ACK same cycle), STALL=0 -> IMEM_ADDR 0,4,8,12 on cycles 1-4; IF_PC 0,4,8 with IF_VALID=1 from cycle 2.
- IMEM with 3-cycle ACK latency -> REQ held 3 cycles, IMEM_ADDR stable, IF_VALID pulses once per transaction.
- STALL=1 for 4 cycles with slot full and ACK arriving -> HOLD entered, IMEM_REQ=0, IF_PC held. On STALL=0, buffered instr appears next, then fetch resumes at +PC_STEP.
- BRANCH_SIG with PC_BRANCH=32'h100 while ACK pending (2 cycles away) -> FLUSH, old data discarded, IF_VALID=0, next IMEM_ADDR=32'h100.
- BRANCH_SIG with STALL=1 and HOLD buf full -> IF_VALID=0 next edge, buf dropped, IMEM_ADDR=PC_BRANCH.
- RSTN low mid-transaction with RESET_PC=32'h40 -> outputs 0 immediately; after release, first IMEM_ADDR=32'h40 and the stray ACK is ignored.
